// File: rtl/palette_pkg.sv
// palette_pkg: shared sizes, colour type, init FSM states and default palette for palette_lookup
package palette_pkg;
   localparam int PAL_ENTRIES = 256;
   localparam int LATENCY = 2;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;
   typedef enum logic {ST_INIT, ST_RUN} init_st_t;
   function automatic rgb444_t default_palette(input logic [7:0] idx);
      logic [7:0] i;
      logic [11:0] c;
      i = idx - 8'd32;
      c = 12'h000;
      if (idx < 8'd16) begin
         case (idx[3:0])
            4'h0: c = 12'h000;
            4'h1: c = 12'hFFF;
            4'h2: c = 12'h800;
            4'h3: c = 12'hAFE;
            4'h4: c = 12'hC4C;
            4'h5: c = 12'h0C5;
            4'h6: c = 12'h00A;
            4'h7: c = 12'hEE7;
            4'h8: c = 12'hD85;
            4'h9: c = 12'h640;
            4'hA: c = 12'hF77;
            4'hB: c = 12'h333;
            4'hC: c = 12'h777;
            4'hD: c = 12'hAF6;
            4'hE: c = 12'h08F;
            default: c = 12'hBBB;
         endcase
      end else if (idx < 8'd32) c = {3{idx[3:0]}};
      else c = {(i[4] | i[7]) ? i[3:0] : {1'b0, i[3:1]},
                i[5] ? i[3:0] : {2'b0, i[3:2]},
                i[6] ? i[3:0] : {1'b0, i[3:1]}};
      return rgb444_t'(c);
   endfunction
endpackage

// File: rtl/palette_ram_dp.sv
// palette_ram_dp: 256x12 palette RAM, pixel read port plus CPU port with {G,B}/R lane write enables
module palette_ram_dp
   import palette_pkg::*;
(
   input  logic        clk,
   input  logic [7:0]  addr_a,
   output logic [11:0] q_a,
   input  logic [7:0]  addr_b,
   input  logic        rd_b,
   input  logic        we_gb,
   input  logic        we_r,
   input  logic [7:0]  wd_gb,
   input  logic [3:0]  wd_r,
   output logic [7:0]  q_gb,
   output logic [3:0]  q_r
);
   logic [7:0] mem_gb [PAL_ENTRIES];
   logic [3:0] mem_r [PAL_ENTRIES];
   // pixel port: registered read every cycle
   always_ff @(posedge clk) q_a <= {mem_r[addr_a], mem_gb[addr_a]};
   // CPU port: read-before-write, read register holds until the next read
   always_ff @(posedge clk) begin
      if (rd_b) begin
         q_gb <= mem_gb[addr_b];
         q_r <= mem_r[addr_b];
      end
      if (we_gb) mem_gb[addr_b] <= wd_gb;
      if (we_r) mem_r[addr_b] <= wd_r;
   end
endmodule

// File: rtl/palette_lookup.sv
// palette_lookup: index->RGB444 palette stage with sync delay, CPU port, gray mode; PALETTE_DEFAULT_INIT_EN adds default-palette load
module palette_lookup
   import palette_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] pix_index,
   input  logic       pix_strobe,
   input  logic       blank_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       chroma_disable,
   input  logic [8:0] cpu_addr,
   input  logic [7:0] cpu_wrdata,
   input  logic       cpu_write,
   input  logic       cpu_read,
   output logic [7:0] cpu_rddata,
   output logic       init_busy,
   output logic [3:0] rgb_r,
   output logic [3:0] rgb_g,
   output logic [3:0] rgb_b,
   output logic       pix_valid_out,
   output logic       hsync_out,
   output logic       vsync_out
);
   rgb444_t px_s1, def;
   logic blank_s1, hs_s1, vs_s1, stb_s1;
   logic [7:0] idx, addr_b, wd_gb, q_gb;
   logic [3:0] wd_r, q_r, y;
   logic [5:0] luma_sum;
   logic we_gb, we_r, rd_seen, rd_lane, rd_zero;
`ifdef PALETTE_DEFAULT_INIT_EN
   init_st_t st, st_nxt;
   logic [7:0] idx_nxt;
   // init FSM state and entry counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st <= ST_INIT;
         idx <= 8'd0;
      end else begin
         st <= st_nxt;
         idx <= idx_nxt;
      end
   end
   // one default entry per clock, leave INIT after entry 255
   always_comb begin
      st_nxt = st;
      idx_nxt = idx;
      st_nxt = (st == ST_INIT && idx == 8'hFF) ? ST_RUN : st;
      idx_nxt = (st == ST_INIT) ? idx + 8'd1 : idx;
   end
   assign init_busy = (st == ST_INIT);
   assign def = default_palette(idx);
`else
   assign init_busy = 1'b0;
   assign idx = 8'd0;
   assign def = '0;
`endif
   assign addr_b = init_busy ? idx : cpu_addr[8:1];
   assign we_gb = init_busy | (cpu_write & ~cpu_addr[0]);
   assign we_r = init_busy | (cpu_write & cpu_addr[0]);
   assign wd_gb = init_busy ? {def.g, def.b} : cpu_wrdata;
   assign wd_r = init_busy ? def.r : cpu_wrdata[3:0];
   palette_ram_dp u_ram (
      .clk    (clk),
      .addr_a (pix_index),
      .q_a    (px_s1),
      .addr_b (addr_b),
      .rd_b   (cpu_read & ~init_busy),
      .we_gb  (we_gb),
      .we_r   (we_r),
      .wd_gb  (wd_gb),
      .wd_r   (wd_r),
      .q_gb   (q_gb),
      .q_r    (q_r)
   );
   // remember which lane the last CPU read targeted and whether it fell in INIT
   always_ff @(posedge clk) begin
      if (!rst_n) {rd_seen, rd_lane, rd_zero} <= 3'b000;
      else if (cpu_read) {rd_seen, rd_lane, rd_zero} <= {1'b1, cpu_addr[0], init_busy};
   end
   assign cpu_rddata = (!rd_seen || rd_zero) ? 8'h00 : rd_lane ? {4'h0, q_r} : q_gb;
   // S1: controls registered alongside the RAM read
   always_ff @(posedge clk) begin
      if (!rst_n) {blank_s1, hs_s1, vs_s1, stb_s1} <= 4'b0000;
      else {blank_s1, hs_s1, vs_s1, stb_s1} <= {blank_in, hsync_in, vsync_in, pix_strobe};
   end
   assign luma_sum = {2'b00, px_s1.r} + {1'b0, px_s1.g, 1'b0} + {2'b00, px_s1.b} + 6'd2;
   assign y = 4'(luma_sum >> 2);
   // S2: output register with blanking and gray conversion
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         {rgb_r, rgb_g, rgb_b} <= 12'h000;
         {pix_valid_out, hsync_out, vsync_out} <= 3'b000;
      end else begin
         {rgb_r, rgb_g, rgb_b} <= (blank_s1 | init_busy) ? 12'h000 : chroma_disable ? {3{y}} : px_s1;
         {pix_valid_out, hsync_out, vsync_out} <= {stb_s1, hs_s1, vs_s1};
      end
   end
endmodule

// File: tb/tb_palette_lookup.sv
// tb_palette_lookup: directed self-checking bench for palette_lookup
module tb_palette_lookup;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] pix_index = 8'd0, cpu_wrdata = 8'd0;
   logic pix_strobe = 1'b0, blank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, chroma_disable = 1'b0;
   logic [8:0] cpu_addr = 9'd0;
   logic cpu_write = 1'b0, cpu_read = 1'b0;
   logic [7:0] cpu_rddata;
   logic init_busy, pix_valid_out, hsync_out, vsync_out;
   logic [3:0] rgb_r, rgb_g, rgb_b;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   palette_lookup dut (
      .clk(clk), .rst_n(rst_n), .pix_index(pix_index), .pix_strobe(pix_strobe),
      .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .chroma_disable(chroma_disable), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
      .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_rddata(cpu_rddata),
      .init_busy(init_busy), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
      .pix_valid_out(pix_valid_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
      cpu_addr = a;
      cpu_wrdata = d;
      cpu_write = 1'b1;
      tick();
      cpu_write = 1'b0;
   endtask

   task automatic cpu_rd(input logic [8:0] a, output logic [7:0] d);
      cpu_addr = a;
      cpu_read = 1'b1;
      tick();
      cpu_read = 1'b0;
      d = cpu_rddata;
   endtask

   task automatic show(input logic [7:0] idx, input logic blank, input logic chroma, output logic [11:0] c);
      pix_index = idx;
      blank_in = blank;
      chroma_disable = chroma;
      tick();
      tick();
      c = {rgb_r, rgb_g, rgb_b};
   endtask

   task automatic test_reset();
      logic exp_busy;
`ifdef PALETTE_DEFAULT_INIT_EN
      exp_busy = 1'b1;
`else
      exp_busy = 1'b0;
`endif
      rst_n = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      pix_strobe = 1'b1;
      cpu_addr = 9'h002;
      cpu_read = 1'b1;
      repeat (3) tick();
      cpu_read = 1'b0;
      checks++; if ({rgb_r, rgb_g, rgb_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", {rgb_r, rgb_g, rgb_b}); end
      checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid_out); end
      checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL reset_hsync got=%b exp=0", hsync_out); end
      checks++; if (vsync_out !== 1'b0) begin errors++; $display("FAIL reset_vsync got=%b exp=0", vsync_out); end
      checks++; if (cpu_rddata !== 8'h00) begin errors++; $display("FAIL reset_rddata got=%h exp=00", cpu_rddata); end
      checks++; if (init_busy !== exp_busy) begin errors++; $display("FAIL reset_init_busy got=%b exp=%b", init_busy, exp_busy); end
      {hsync_in, vsync_in, pix_strobe} = 3'b000;
      rst_n = 1'b1;
   endtask

`ifdef PALETTE_DEFAULT_INIT_EN
   task automatic run_init(output int n, output logic [7:0] rd_in, output logic [11:0] rgb_mid, output logic hs_mid);
      n = 0;
      rd_in = 8'hEE;
      rgb_mid = 12'hEEE;
      hs_mid = 1'b0;
      hsync_in = 1'b1;
      while (init_busy && n < 1000) begin
         if (n == 10) begin cpu_addr = 9'h002; cpu_wrdata = 8'h00; cpu_write = 1'b1; end
         if (n == 11) cpu_write = 1'b0;
         if (n == 20) begin cpu_addr = 9'h003; cpu_read = 1'b1; end
         if (n == 21) begin cpu_read = 1'b0; rd_in = cpu_rddata; end
         if (n == 50) begin rgb_mid = {rgb_r, rgb_g, rgb_b}; hs_mid = hsync_out; end
         tick();
         n++;
      end
      hsync_in = 1'b0;
   endtask

   task automatic test_init();
      int n;
      logic [7:0] rd, d;
      logic [11:0] c;
      logic h;
      run_init(n, rd, c, h);
      checks++; if (n !== 256) begin errors++; $display("FAIL init_busy_len got=%0d exp=256", n); end
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL init_read got=%h exp=00", rd); end
      checks++; if (c !== 12'h000) begin errors++; $display("FAIL init_rgb got=%h exp=000", c); end
      checks++; if (h !== 1'b1) begin errors++; $display("FAIL init_hsync_pass got=%b exp=1", h); end
      cpu_rd(9'h002, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL init_entry1_gb got=%h exp=FF", d); end
      cpu_rd(9'h003, d);
      checks++; if (d !== 8'h0F) begin errors++; $display("FAIL init_entry1_r got=%h exp=0F", d); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (100) tick();
      checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL init_mid_busy got=%b exp=1", init_busy); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run_init(n, rd, c, h);
      checks++; if (n !== 256) begin errors++; $display("FAIL init_restart_len got=%0d exp=256", n); end
      cpu_rd(9'h002, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL init_write_dropped got=%h exp=FF", d); end
   endtask
`endif

   task automatic test_lanes();
      logic [7:0] d;
      logic [11:0] c;
      cpu_wr(9'h0A0, 8'h5A);
      cpu_wr(9'h0A1, 8'hF3);
      show(8'h50, 1'b0, 1'b0, c);
      checks++; if (c !== 12'h35A) begin errors++; $display("FAIL lanes_rgb got=%h exp=35A", c); end
      cpu_rd(9'h0A1, d);
      checks++; if (d !== 8'h03) begin errors++; $display("FAIL lanes_rd_r got=%h exp=03", d); end
      cpu_rd(9'h0A0, d);
      checks++; if (d !== 8'h5A) begin errors++; $display("FAIL lanes_rd_gb got=%h exp=5A", d); end
      cpu_addr = 9'h0A1;
      repeat (3) tick();
      checks++; if (cpu_rddata !== 8'h5A) begin errors++; $display("FAIL rddata_hold got=%h exp=5A", cpu_rddata); end
      show(8'h50, 1'b1, 1'b0, c);
      checks++; if (c !== 12'h000) begin errors++; $display("FAIL lanes_blank got=%h exp=000", c); end
   endtask

   task automatic test_chroma();
      logic [7:0] d;
      logic [11:0] c;
      cpu_wr(9'h040, 8'h00);
      cpu_wr(9'h041, 8'h0F);
      cpu_wr(9'h042, 8'hFF);
      cpu_wr(9'h043, 8'hFF);
      show(8'h20, 1'b0, 1'b1, c);
      checks++; if (c !== 12'h444) begin errors++; $display("FAIL gray_red got=%h exp=444", c); end
      show(8'h50, 1'b0, 1'b1, c);
      checks++; if (c !== 12'h666) begin errors++; $display("FAIL gray_35A got=%h exp=666", c); end
      show(8'h21, 1'b0, 1'b1, c);
      checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL gray_max got=%h exp=FFF", c); end
      show(8'h20, 1'b0, 1'b0, c);
      checks++; if (c !== 12'hF00) begin errors++; $display("FAIL colour_red got=%h exp=F00", c); end
      show(8'h20, 1'b1, 1'b1, c);
      checks++; if (c !== 12'h000) begin errors++; $display("FAIL gray_blank got=%h exp=000", c); end
      chroma_disable = 1'b0;
      cpu_rd(9'h043, d);
      checks++; if (d !== 8'h0F) begin errors++; $display("FAIL r_lane_upper_ignored got=%h exp=0F", d); end
   endtask

   task automatic test_pipeline();
      logic [5:0] vec [8];
      logic [7:0] idxs [3];
      logic [11:0] cols [3];
      logic [14:0] exp_o, got;
      vec = '{6'b010100, 6'b001101, 6'b111010, 6'b000110, 6'b100100, 6'b011001, 6'b000000, 6'b110101};
      idxs = '{8'h50, 8'h20, 8'h21};
      cols = '{12'h35A, 12'hF00, 12'hFFF};
      chroma_disable = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            {blank_in, hsync_in, vsync_in, pix_strobe} = vec[i][5:2];
            pix_index = idxs[vec[i][1:0]];
         end else begin
            {blank_in, hsync_in, vsync_in, pix_strobe} = 4'b0000;
         end
         tick();
         if (i >= 1) begin
            exp_o = {vec[i-1][4], vec[i-1][3], vec[i-1][2], vec[i-1][5] ? 12'h000 : cols[vec[i-1][1:0]]};
            got = {hsync_out, vsync_out, pix_valid_out, rgb_r, rgb_g, rgb_b};
            checks++; if (got !== exp_o) begin errors++; $display("FAIL pipe[%0d] got=%h exp=%h", i - 1, got, exp_o); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      cpu_wr(9'h00E, 8'h12);
      cpu_wr(9'h00F, 8'h03);
      blank_in = 1'b0;
      chroma_disable = 1'b0;
      pix_index = 8'h07;
      cpu_addr = 9'h00E;
      cpu_wrdata = 8'hAB;
      cpu_write = 1'b1;
      tick();
      cpu_write = 1'b0;
      tick();
      checks++; if ({rgb_r, rgb_g, rgb_b} !== 12'h312) begin errors++; $display("FAIL collide_old got=%h exp=312", {rgb_r, rgb_g, rgb_b}); end
      tick();
      checks++; if ({rgb_r, rgb_g, rgb_b} !== 12'h3AB) begin errors++; $display("FAIL collide_new got=%h exp=3AB", {rgb_r, rgb_g, rgb_b}); end
      cpu_wrdata = 8'hCD;
      cpu_write = 1'b1;
      cpu_read = 1'b1;
      tick();
      cpu_write = 1'b0;
      cpu_read = 1'b0;
      checks++; if (cpu_rddata !== 8'hAB) begin errors++; $display("FAIL rw_same_cycle got=%h exp=AB", cpu_rddata); end
      cpu_rd(9'h00E, d);
      checks++; if (d !== 8'hCD) begin errors++; $display("FAIL rw_write_wins got=%h exp=CD", d); end
      tick();
      checks++; if ({rgb_r, rgb_g, rgb_b} !== 12'h3CD) begin errors++; $display("FAIL rw_pixel got=%h exp=3CD", {rgb_r, rgb_g, rgb_b}); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
`ifdef PALETTE_DEFAULT_INIT_EN
      test_init();
`endif
      test_lanes();
      test_chroma();
      test_pipeline();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
